// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: CPU stores to DATA fill a small FIFO that a
// baud-rate shifter drains onto tx; STATUS is read back with one-cycle latency.
module uart_tx_mmio #(
    parameter logic [15:0] BASE_ADDR    = 16'hF000,
    parameter int          CLKS_PER_BIT = 139,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] dbus_addr,
    input  logic [31:0] dbus_write,
    input  logic        dbus_wen,
    output logic [31:0] dbus_read,
    output logic        tx,
    output logic [1:0]  dbg_state_o
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    state_e              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [2:0]          idx_q, idx_d;
    logic [7:0]          shift_q, shift_d;
    logic                tx_q, tx_d;
    logic [PTR_W-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                overflow_q, overflow_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [7:0]          mem_q [FIFO_DEPTH];

    logic        sel_data, sel_stat, full, empty, push, pop, baud_last;
    logic [31:0] cnt_ext;
    logic [3:0]  cnt_sat;
    logic [31:0] status;

    // The bus has no handshake: a store is accepted on every edge where dbus_wen is high.
    assign sel_data  = (dbus_addr == BASE_ADDR);
    assign sel_stat  = (dbus_addr == BASE_ADDR + 16'd1);
    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign push      = dbus_wen && sel_data && !full;
    assign baud_last = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + BAUD_W'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    idx_d   = 3'd0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (idx_q == 3'd7) state_d = S_STOP;
                    else               idx_d   = idx_q + 3'd1;
                end
            end
            S_STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when more data is queued.
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[idx_d];
            default: tx_d = 1'b1;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        overflow_d = overflow_q;
        if (dbus_wen && sel_data && full)                overflow_d = 1'b1;
        else if (dbus_wen && sel_stat && dbus_write[3]) overflow_d = 1'b0;

        cnt_ext = 32'(count_q);
        cnt_sat = (cnt_ext > 32'd15) ? 4'hF : cnt_ext[3:0];
        status  = {24'd0, cnt_sat, overflow_q, (state_q != S_IDLE), empty, full};
        rdata_d = (sel_data || sel_stat) ? status : 32'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            rdata_q    <= rdata_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= dbus_write[7:0];
    end

    assign tx          = tx_q;
    assign dbus_read   = rdata_q;
    assign dbg_state_o = state_q;
endmodule
